// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache block refill responder.
package cache_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } fill_state_e;

  localparam int unsigned WORDS_PER_BLOCK_DEFAULT = 8;
  localparam int unsigned MEM_LATENCY_DEFAULT     = 4;
  localparam int unsigned ADDR_W_DEFAULT          = 16;

  // Word-offset width for the default block size.
  localparam int unsigned OFFSET_W = $clog2(WORDS_PER_BLOCK_DEFAULT);

  // Byte-offset bits inside one default-sized block (16-bit words, so one extra bit).
  localparam logic [ADDR_W_DEFAULT-1:0] BLOCK_BYTE_MASK =
      ADDR_W_DEFAULT'(2 * WORDS_PER_BLOCK_DEFAULT - 1);

  // Cycles fsm_busy stays high from the miss cycle to release.
  function automatic int unsigned release_cycles(input int unsigned wpb, input int unsigned lat);
    return 1 + wpb + lat - 1;
  endfunction

  localparam int unsigned RELEASE_CYCLES =
      release_cycles(WORDS_PER_BLOCK_DEFAULT, MEM_LATENCY_DEFAULT);

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear; done flags the terminal count.
module fill_counter #(
  parameter int unsigned Width    = 4,
  parameter int unsigned MaxCount = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == Width'(MaxCount));
  assign cnt_o  = cnt_q;

  // Clear wins over increment; the count holds once it reaches MaxCount.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block refill responder: stalls the pipeline on a miss, issues one word read per cycle
// to main memory, steers returned words into the data array and writes the tag with the last
// word. Optional macro CACHE_CRITICAL_WORD_FIRST_EN starts both issue and receive order at the
// missed word and wraps around the block.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEFAULT,
  parameter int unsigned MEM_LATENCY     = MEM_LATENCY_DEFAULT,
  parameter int unsigned ADDR_W          = ADDR_W_DEFAULT,
  localparam int unsigned OffW           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              miss_detected_i,
  input  logic [ADDR_W-1:0] miss_address_i,
  output logic              fsm_busy_o,
  output logic              mem_read_en_o,
  output logic [ADDR_W-1:0] memory_address_o,
  input  logic              memory_data_valid_i,
  output logic              write_data_array_o,
  output logic [OffW-1:0]   fill_word_offset_o,
  output logic              write_tag_array_o
);

  localparam int unsigned CntW = OffW + 1;
  localparam logic [ADDR_W-1:0] BlockMask = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY < 1) begin : gen_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end
  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : gen_bad_wpb
    $error("WORDS_PER_BLOCK must be a power of two and at least 2");
  end

  fill_state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [CntW-1:0]   issue_cnt, recv_cnt;
  logic              issue_done, recv_done;
  logic              issue_en, recv_en, cnt_clr, take_miss;
  logic [OffW-1:0]   issue_word, recv_word;

  fill_counter #(
    .Width   (CntW),
    .MaxCount(WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .en_i   (issue_en),
    .cnt_o  (issue_cnt),
    .done_o (issue_done)
  );

  fill_counter #(
    .Width   (CntW),
    .MaxCount(WORDS_PER_BLOCK)
  ) u_recv_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .en_i   (recv_en),
    .cnt_o  (recv_cnt),
    .done_o (recv_done)
  );

  // Issue MSB is covered by issue_done; recv never saturates because completion clears it.
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{issue_cnt[OffW], recv_done};

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic [OffW-1:0] miss_off_q;

  // Offset adds wrap naturally at OffW bits.
  assign issue_word = miss_off_q + issue_cnt[OffW-1:0];
  assign recv_word  = miss_off_q + recv_cnt[OffW-1:0];

  // Word offset of the missed access, captured with the base.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_off_q <= '0;
    end else if (take_miss) begin
      miss_off_q <= miss_address_i[OffW:1];
    end
  end
`else
  assign issue_word = issue_cnt[OffW-1:0];
  assign recv_word  = recv_cnt[OffW-1:0];
`endif

  // Next-state and output decode; issue and receive run concurrently during a fill.
  always_comb begin
    state_d            = state_q;
    fsm_busy_o         = 1'b0;
    mem_read_en_o      = 1'b0;
    mem_addr           = addr_q;
    write_data_array_o = 1'b0;
    fill_word_offset_o = '0;
    write_tag_array_o  = 1'b0;
    issue_en           = 1'b0;
    recv_en            = 1'b0;
    cnt_clr            = 1'b0;
    take_miss          = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Stall in the miss cycle itself.
        fsm_busy_o = miss_detected_i;
        if (miss_detected_i) begin
          take_miss = 1'b1;
          state_d   = StFill;
        end
      end
      StFill: begin
        fsm_busy_o = 1'b1;
        if (!issue_done) begin
          mem_read_en_o = 1'b1;
          mem_addr      = base_q + ADDR_W'({issue_word, 1'b0});
          issue_en      = 1'b1;
        end
        if (memory_data_valid_i) begin
          write_data_array_o = 1'b1;
          fill_word_offset_o = recv_word;
          recv_en            = 1'b1;
          if (recv_cnt == CntW'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array_o = 1'b1;
            cnt_clr           = 1'b1;
            state_d           = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign memory_address_o = mem_addr;

  // State, block base and last-issued address registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      base_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= mem_addr;
      if (take_miss) begin
        base_q <= miss_address_i & ~BlockMask;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm. A queue-based reference model holds the list of
// addresses still to issue and word slots still to receive for the active fill. The memory
// model returns a read issued in cycle c during cycle c + MEM_LATENCY - 1, counting the issue
// cycle as the first latency cycle, which gives the 12-cycle miss-to-release window.
module tb_cache_fill_fsm;

  localparam int WPB = 8;
  localparam int LAT = 4;
  localparam int RELEASE = 1 + WPB + LAT - 1;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, miss, mem_valid, stray;
  logic [15:0] maddr;
  logic        busy, rd, wr, tag;
  logic [15:0] addr;
  logic [2:0]  off;

  cache_fill_fsm #(
    .WORDS_PER_BLOCK(WPB),
    .MEM_LATENCY    (LAT),
    .ADDR_W         (16)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .miss_detected_i    (miss),
    .miss_address_i     (maddr),
    .fsm_busy_o         (busy),
    .mem_read_en_o      (rd),
    .memory_address_o   (addr),
    .memory_data_valid_i(mem_valid),
    .write_data_array_o (wr),
    .fill_word_offset_o (off),
    .write_tag_array_o  (tag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rd_hist [64];

  // Reference model state.
  bit          m_active = 1'b0;
  logic [15:0] m_issue[$];
  logic [2:0]  m_recv[$];
  logic [15:0] m_last_addr = '0;

  // Sampled DUT outputs and model expectations for the current cycle.
  logic        o_busy, o_rd, o_wr, o_tag;
  logic [15:0] o_addr;
  logic [2:0]  o_off;
  logic [22:0] obs_v, exp_v;

  // Advance one clock: drive memory returns, sample at negedge, then step the model.
  task automatic cycle();
    logic        e_busy, e_rd, e_wr, e_tag;
    logic [15:0] e_addr, base;
    logic [2:0]  e_off, moff, w;
    mem_valid = stray | ((cyc >= LAT - 1) && rd_hist[(cyc - (LAT - 1)) % 64]);
    @(negedge clk);
    o_busy = busy; o_rd = rd; o_addr = addr; o_wr = wr; o_off = off; o_tag = tag;
    obs_v  = {o_busy, o_rd, o_addr, o_wr, o_off, o_tag};
    e_busy = m_active | miss;
    e_rd = 1'b0; e_addr = m_last_addr; e_wr = 1'b0; e_off = '0; e_tag = 1'b0;
    if (m_active) begin
      if (m_issue.size() > 0) begin
        e_rd   = 1'b1;
        e_addr = m_issue[0];
      end
      if (mem_valid && m_recv.size() > 0) begin
        e_wr  = 1'b1;
        e_off = m_recv[0];
        e_tag = (m_recv.size() == 1);
      end
    end
    exp_v = {e_busy, e_rd, e_addr, e_wr, e_off, e_tag};
    rd_hist[cyc % 64] = rd;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_issue.delete();
      m_recv.delete();
      m_last_addr = '0;
    end else begin
      m_last_addr = e_addr;
      if (m_active) begin
        if (e_rd) void'(m_issue.pop_front());
        if (e_wr) begin
          void'(m_recv.pop_front());
          if (e_tag) m_active = 1'b0;
        end
      end else if (miss) begin
        base = maddr & ~16'h000F;
        moff = maddr[3:1];
        for (int i = 0; i < WPB; i++) begin
          w = Cwf ? 3'(moff + 3'(i)) : 3'(i);
          m_issue.push_back(base + 16'({w, 1'b0}));
          m_recv.push_back(w);
        end
        m_active = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; miss = 1'b0; maddr = '0; stray = 1'b0;
    cycle();
    cycle();
    total++;
    if (obs_v !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", obs_v);
    end
    rst = 1'b0;
    cycle();
    total++;
    if (obs_v !== exp_v) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_basic();
    int          busy_n = 0;
    int          n = 0;
    bit          seen = 1'b0;
    logic [15:0] first_a = '0;
    logic [2:0]  tag_off = '0;
    int          tags = 0;
    miss = 1'b1; maddr = 16'h1236;
    while (n < 40) begin
      cycle();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL basic cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (o_busy) busy_n++;
      if (o_rd && !seen) begin seen = 1'b1; first_a = o_addr; end
      if (o_tag) begin tags++; tag_off = o_off; end
      miss = 1'b0;
      n++;
      if (n > 1 && !o_busy) break;
    end
    total++;
    if (n >= 40) begin
      bad++; $display("FAIL basic_timeout busy still %b after %0d cycles, want 0", o_busy, n);
    end
    total++;
    if (busy_n != RELEASE) begin
      bad++; $display("FAIL basic_busy_len got=%0d want=%0d", busy_n, RELEASE);
    end
    total++;
    if (first_a !== (Cwf ? 16'h1236 : 16'h1230)) begin
      bad++; $display("FAIL basic_first_addr got=%h want=%h", first_a, Cwf ? 16'h1236 : 16'h1230);
    end
    total++;
    if (tags != 1 || tag_off !== (Cwf ? 3'd2 : 3'd7)) begin
      bad++; $display("FAIL basic_tag count=%0d off=%0d want 1 at %0d", tags, tag_off, Cwf ? 2 : 7);
    end
  endtask

  task automatic test_miss_during_fill();
    miss = 1'b1; maddr = 16'h1236;
    for (int i = 0; i < 13; i++) begin
      cycle();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL midfill cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (i > 0 && o_rd && o_addr[15:4] !== 12'h123) begin
        total++; bad++;
        $display("FAIL midfill_addr got=%h want block 0x123x", o_addr);
      end
      miss = (i == 4);
      if (i == 4) maddr = 16'h4000;
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL midfill_released busy=%b want 0", o_busy);
    end
    miss = 1'b1; maddr = 16'h4000;
    cycle();
    total++;
    if (obs_v !== exp_v || o_busy !== 1'b1) begin
      bad++; $display("FAIL midfill_retake got=%h want=%h", obs_v, exp_v);
    end
    miss = 1'b0;
    cycle();
    total++;
    if (o_rd !== 1'b1 || o_addr !== 16'h4000) begin
      bad++; $display("FAIL midfill_new_addr rd=%b addr=%h want rd=1 addr=4000", o_rd, o_addr);
    end
    for (int i = 0; i < 12; i++) begin
      cycle();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL midfill_drain cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    miss = 1'b1; maddr = 16'h0A1C;
    for (int i = 0; i <= 6; i++) begin
      cycle();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL rstfill cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      miss = 1'b0;
      rst  = (i == 5);
    end
    rst = 1'b0;
    cycle();
    total++;
    if (obs_v !== '0) begin
      bad++; $display("FAIL rstfill_zero got=%h want=0", obs_v);
    end
    for (int i = 0; i < 12; i++) begin
      cycle();
      total++;
      if (obs_v !== exp_v || o_wr !== 1'b0 || o_tag !== 1'b0) begin
        bad++; $display("FAIL rstfill_ignore cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_n = 0;
    miss = 1'b1; maddr = 16'h1236;
    for (int i = 0; i < 26; i++) begin
      cycle();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (o_busy) busy_n++;
      if (i == 13) begin
        total++;
        if (o_rd !== 1'b1 || o_addr !== (Cwf ? 16'h2A5C : 16'h2A50)) begin
          bad++; $display("FAIL b2b_second_addr rd=%b addr=%h want %h", o_rd, o_addr,
                          Cwf ? 16'h2A5C : 16'h2A50);
        end
      end
      maddr = 16'h2A5C;
      miss  = (i < 22);
    end
    total++;
    if (busy_n != 2 * RELEASE) begin
      bad++; $display("FAIL b2b_busy_len got=%0d want=%0d", busy_n, 2 * RELEASE);
    end
  endtask

  task automatic test_stray_idle();
    miss = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stray = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle();
      total++;
      if (obs_v !== exp_v || o_wr !== 1'b0 || o_tag !== 1'b0 || o_busy !== 1'b0) begin
        bad++; $display("FAIL stray cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
    end
    stray = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 320; i++) begin
      miss  = (i < 300) && ($urandom_range(0, 3) == 0);
      maddr = 16'($urandom);
      stray = !m_active && ($urandom_range(0, 3) == 0);
      cycle();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
    end
    stray = 1'b0; miss = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rd_hist[i] = 1'b0;
    rst = 1'b1; miss = 1'b0; maddr = '0; stray = 1'b0; mem_valid = 1'b0;
    test_reset();
    test_basic();
    test_miss_during_fill();
    test_reset_mid_fill();
    test_back_to_back();
    test_stray_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling responder on the CPU memory interface.
- It drives the pipeline's cache-stall input (NotCacheStall = !fsm_busy) while it refills one direct-mapped cache block from multi-cycle main memory.
- It issues pipelined word reads to main memory, steers returned words into the cache data array, and writes the tag when the last word lands.
- One instance serves the I-cache and one serves the D-cache; a top-level arbiter is out of scope.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of 2).
- MEM_LATENCY, 4, cycles from read issue to memory_data_valid (≥1).
- ADDR_W, 16, byte address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- miss_detected  in  1  tag-compare miss from the cache, sampled in IDLE only
- miss_address  in  ADDR_W  byte address of the missing access
- fsm_busy  out  1  stall request to the pipeline
- mem_read_en  out  1  read strobe to main memory, one word per cycle
- memory_address  out  ADDR_W  byte address of the word being issued
- memory_data_valid  in  1  returned word valid, MEM_LATENCY cycles after issue
- write_data_array  out  1  write enable to the data array
- fill_word_offset  out  log2(WORDS_PER_BLOCK)  word slot being written
- write_tag_array  out  1  tag/valid write enable, asserted with the last data write

Behaviour:
Reset:
- rst sampled high: state=IDLE, issue_cnt=0, recv_cnt=0, base=0.
- All outputs 0 on the following cycle.
- Reset mid-FILL abandons the fill; the tag is never written.
- memory_data_valid pulses arriving after reset are ignored.

States IDLE and FILL:
- IDLE: fsm_busy = miss_detected (combinational), so the pipeline stalls in the miss cycle itself.
- IDLE with miss_detected=1: latch base = miss_address with low log2(WORDS_PER_BLOCK)+1 bits cleared; latch miss word offset = miss_address[log2(WPB):1]; next state FILL.
- FILL: fsm_busy=1 every cycle.

Issue side:
- While issue_cnt < WORDS_PER_BLOCK: mem_read_en=1, memory_address = base + 2*issue_word, issue_cnt++.
- Otherwise mem_read_en=0 and memory_address holds its last value.
- Issue begins in the first FILL cycle.

Receive side:
- Each memory_data_valid in FILL: write_data_array=1, fill_word_offset = recv_word, recv_cnt++.
- Words return in issue order.
- memory_data_valid in IDLE is ignored: no writes.

Completion and timing:
- On the valid that makes recv_cnt = WORDS_PER_BLOCK, write_tag_array=1 in the same cycle as the final data write.
- Next state IDLE; counters clear.
- fsm_busy drops the following cycle unless a new miss_detected is present.
- Miss-to-release: fsm_busy is high for exactly 1 + WORDS_PER_BLOCK + MEM_LATENCY − 1 cycles, i.e. 12 cycles with defaults.

Counter and arithmetic rules:
- Counters are log2(WPB)+1 bits wide.
- Word offsets wrap modulo WORDS_PER_BLOCK.
- Address addition is truncated to ADDR_W; the base is block-aligned, so it cannot overflow.

Boundary cases:
- miss_detected during FILL is ignored and is not queued; the cache re-asserts it after release.
- miss_detected in the completion cycle is also ignored; it is taken in the next IDLE cycle.
- The FSM never stalls issue; memory is assumed to accept one read per cycle.

Optional Feature:
- Macro: CACHE_CRITICAL_WORD_FIRST_EN.
- Defined: issue_word and recv_word = (miss_offset + cnt) mod WORDS_PER_BLOCK, so the missed word is fetched first and order wraps. Example: miss offset 5 gives order 5,6,7,0,1,2,3,4. Total latency is unchanged.
- Undefined: order is always 0..WORDS_PER_BLOCK−1 and miss_offset is not stored.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, FILL}
  - WORDS_PER_BLOCK, MEM_LATENCY defaults
  - OFFSET_W = log2(WPB)
  - BLOCK_BYTE_MASK constant
  - localparam for release cycles
- Sub-module fill_counter: saturating up-counter with clear, enable, done flag, width parameter. It is instantiated twice, for issue_cnt and recv_cnt.

Test Plan:
- Reset, then miss_address=0x1236 with miss_detected for 1 cycle → fsm_busy=1 same cycle; memory_address 0x1230,0x1232…0x123E on 8 consecutive cycles; 8 write_data_array pulses, offsets 0..7; write_tag_array with the 8th; fsm_busy high 12 cycles total.
- Run the first scenario again with CACHE_CRITICAL_WORD_FIRST_EN defined → first address 0x1236; offsets 3,4,5,6,7,0,1,2; tag written on the offset-2 write.
- Re-pulse miss_detected (miss_address=0x4000) at cycle 5 of a fill → ignored: no address change, no second fill; after release, a held miss starts a fill to 0x4000.
- Assert rst at cycle 6 of a fill → next cycle all outputs 0, IDLE; remaining memory_data_valid pulses produce no write_data_array or write_tag_array.
- Back-to-back misses: miss_detected held high through completion → fsm_busy drops exactly one cycle … then re-asserts in IDLE combinationally. Correction: busy stays high via the IDLE-combinational term, and the second fill's addresses start the cycle after the tag write.
- Stray memory_data_valid in IDLE with miss_detected=0 → no write strobes, fsm_busy=0.
